// File: rtl/spi_regmap_pkg.sv
`default_nettype none
// ============================================================================
// spi_regmap_pkg : shared constants and FSM state type for spi_peripheral
// Revision       : 1.0
// ============================================================================
package spi_regmap_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage : spi_regmap_pkg
`default_nettype wire

// File: rtl/spi_peripheral_if.sv
`default_nettype none
// ============================================================================
// spi_peripheral_if : SPI pins plus the five configuration register outputs
// Revision          : 1.0
// ============================================================================
interface spi_peripheral_if;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;

    modport master (
        output sclk, copi, ncs,
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
               en_reg_pwm_15_8, pwm_duty_cycle
    );

    modport slave (
        input  sclk, copi, ncs,
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
               en_reg_pwm_15_8, pwm_duty_cycle
    );
endinterface : spi_peripheral_if
`default_nettype wire

// File: rtl/spi_peripheral_sync_edge.sv
`default_nettype none
// ============================================================================
// sync_edge : multi-flop pin synchronizer with rise/fall pulse outputs
// Revision  : 1.0
// ============================================================================
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_d,
    output logic      o_q,
    output logic      o_rise,
    output logic      o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // r_sync[0] is the metastability-catching stage; r_prev exists only for edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_q    = r_sync[SYNC_STAGES-1];
    assign o_rise =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule : sync_edge
`default_nettype wire

// File: rtl/spi_peripheral.sv
`default_nettype none
// ============================================================================
// spi_peripheral : write-only SPI target holding the pwm_peripheral registers
// Revision       : 1.0
// ============================================================================
module spi_peripheral
    import spi_regmap_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    spi_peripheral_if.slave   bus
);

    localparam logic [6:0] c_max_addr = 7'(MAX_ADDR);
    localparam int         c_settle_w = $clog2(SYNC_STAGES + 1);
    localparam logic [c_settle_w-1:0] c_settle_end = c_settle_w'(SYNC_STAGES);

    logic w_sclk_rise, w_sclk_s_unused, w_sclk_fall_unused;
    logic w_ncs_s, w_ncs_rise, w_ncs_fall;
    logic w_copi_s, w_copi_rise_unused, w_copi_fall_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_d(bus.sclk),
        .o_q(w_sclk_s_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .i_d(bus.ncs),
        .o_q(w_ncs_s), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .i_d(bus.copi),
        .o_q(w_copi_s), .o_rise(w_copi_rise_unused), .o_fall(w_copi_fall_unused)
    );

    state_t                  r_state;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [4:0]              r_count;
    logic [c_settle_w-1:0]   r_settle;
    logic                    r_armed;
    logic [7:0]              r_out_lo, r_out_hi, r_pwm_lo, r_pwm_hi, r_duty;

    logic w_settled;
    logic w_frame_ok;

    assign w_settled  = (r_settle == c_settle_end);
    assign w_frame_ok = (r_count == 5'(FRAME_BITS)) && r_shift[15] &&
                        (r_shift[14:8] <= c_max_addr);

    // The reset value of the nCS chain can mask a pin held low across reset, so
    // a frame may only start once nCS has been seen high at the settled chain output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_count  <= '0;
            r_settle <= '0;
            r_armed  <= 1'b0;
            r_out_lo <= 8'h00;
            r_out_hi <= 8'h00;
            r_pwm_lo <= 8'h00;
            r_pwm_hi <= 8'h00;
            r_duty   <= 8'h00;
        end else begin
            if (!w_settled) begin
                r_settle <= r_settle + 1'b1;
            end
            if (w_settled && w_ncs_s) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_ncs_fall && r_armed) begin
                        r_state <= SHIFT;
                        r_shift <= '0;
                        r_count <= '0;
                    end
                end
                SHIFT: begin
                    // nCS rise takes priority over a coincident SCLK rise.
                    if (w_ncs_rise) begin
                        r_state <= COMMIT;
                    end else if (w_sclk_rise) begin
                        r_shift <= {r_shift[FRAME_BITS-2:0], w_copi_s};
                        if (r_count != 5'd17) begin
                            r_count <= r_count + 5'd1;
                        end
                    end
                end
                COMMIT: begin
                    if (w_frame_ok) begin
                        case (r_shift[14:8])
                            ADDR_EN_OUT_7_0:  r_out_lo <= r_shift[7:0];
                            ADDR_EN_OUT_15_8: r_out_hi <= r_shift[7:0];
                            ADDR_EN_PWM_7_0:  r_pwm_lo <= r_shift[7:0];
                            ADDR_EN_PWM_15_8: r_pwm_hi <= r_shift[7:0];
                            ADDR_PWM_DUTY:    r_duty   <= r_shift[7:0];
                            default: ;
                        endcase
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.en_reg_out_7_0  = r_out_lo;
    assign bus.en_reg_out_15_8 = r_out_hi;
    assign bus.en_reg_pwm_7_0  = r_pwm_lo;
    assign bus.en_reg_pwm_15_8 = r_pwm_hi;
    assign bus.pwm_duty_cycle  = r_duty;

endmodule : spi_peripheral
`default_nettype wire

// File: doc/spi_peripheral.md
# spi_peripheral

Write-only SPI target that holds the five configuration registers for `pwm_peripheral`: output enables, PWM enables and duty cycle. It sits between the chip-level `ui_in` pins (SCLK, COPI, nCS) and `pwm_peripheral` in the top level. It oversamples the SPI pins with the system clock, assembles 16-bit frames and commits a frame to a register only after the frame closes cleanly.

## Interface
- `SYNC_STAGES`, 2: flops in each pin synchronizer, minimum 2.
- `MAX_ADDR`, 4: highest valid register address.

- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `sclk` in 1: SPI clock (`ui_in[0]`), asynchronous to `clk`, idles low (mode 0).
- `copi` in 1: SPI data in (`ui_in[1]`), asynchronous.
- `ncs` in 1: SPI chip select (`ui_in[2]`), active-low, asynchronous.
- `en_reg_out_7_0` out 8: address 0x00, output enable for `uo_out[7:0]`.
- `en_reg_out_15_8` out 8: address 0x01, output enable for `uio_out[7:0]`.
- `en_reg_pwm_7_0` out 8: address 0x02, PWM enable for `uo_out[7:0]`.
- `en_reg_pwm_15_8` out 8: address 0x03, PWM enable for `uio_out[7:0]`.
- `pwm_duty_cycle` out 8: address 0x04, duty cycle (0x00 = 0 %, 0xFF = 100 %).

## Operation
- **Synchronizers.** Each of `sclk`, `ncs` and `copi` passes through `SYNC_STAGES` flops. `sclk` and `ncs` each get one extra flop for edge detection. Synchronizer reset values: `sclk` chain 0, `ncs` chain 1, `copi` chain 0.
- **Frame format.** 16 bits, MSB first, sampled on synchronized SCLK rising edges.
  - bit 15: R/W (1 = write).
  - bits 14:8: address.
  - bits 7:0: data.
- **FSM states.**
  - IDLE: wait for synchronized nCS falling edge → SHIFT. On entry to SHIFT, clear the shift register and the bit counter.
  - SHIFT: on each SCLK rising edge, shift in COPI and increment the 5-bit bit counter. The counter saturates at 17, so 17 or more bits all read as "too many". On nCS rising edge → COMMIT.
  - COMMIT: write the data byte only if all three hold: count == 16, bit 15 == 1, address ≤ `MAX_ADDR`. Then → IDLE, unconditionally.
- **Discards.** Frames of ≠16 bits, reads (bit 15 = 0) and out-of-range addresses are dropped silently; no register changes. There is no read-back path.
- **Repeated writes.** Consecutive frames to the same address: the last committed value wins.
- **Edge ordering.** SCLK edges seen while in IDLE or COMMIT are ignored. If an SCLK rising edge and an nCS rising edge are detected in the same cycle, the nCS edge wins and that SCLK edge is not counted.
- **Reset mid-frame.** Asserting `rst_n` low clears all five registers, the FSM and the synchronizers. If nCS is still low after reset releases, the rest of that frame is ignored; a new nCS falling edge is required.
- **Reset values.** Every output is 0x00.

## Timing
- **Write latency.** Let edge E1 be the first `clk` edge that samples `ncs` high at the pin (with `SYNC_STAGES` = 2):
  - E2: synchronized nCS is high.
  - E3: FSM enters COMMIT.
  - E4: register updates; the new value is visible after E4.
  - In general: commit at E(`SYNC_STAGES`+2).
- **SCLK constraint.** SCLK high and low phases must each be ≥ 3 `clk` periods.
- **COPI constraint.** COPI must be stable from 1 `clk` period before the SCLK rising edge at the pin until `SYNC_STAGES`+1 periods after it.
- **nCS spacing.** nCS high time between frames must be ≥ `SYNC_STAGES`+2 `clk` periods. A shorter high time may lose the next frame but must never corrupt a register.
- **Output stability.** Outputs are registered and change only on a COMMIT cycle or on reset.

## Structure
- Shared package `spi_regmap_pkg`:
  - `FRAME_BITS` = 16.
  - Address constants `ADDR_EN_OUT_7_0` = 7'h00 … `ADDR_PWM_DUTY` = 7'h04.
  - FSM state enum {IDLE, SHIFT, COMMIT}.
- Sub-module `sync_edge`: a `SYNC_STAGES`-deep synchronizer with rise/fall pulse outputs. Instantiate it for `sclk` and `ncs`; use its synchronized output only for `copi`.
- Top-level integration drives `sclk`/`copi`/`ncs` from `ui_in[0..2]` and wires the five outputs into `pwm_peripheral`.

## Test plan
- Reset, then idle pins for 20 cycles → all five outputs are 0x00.
- Write frame 0x80F0 (addr 0x00, data 0xF0) with SCLK = `clk`/8 → `en_reg_out_7_0` = 0xF0 exactly 4 cycles after nCS rises; the other four registers stay 0x00.
- Write 0x8480, 0x02 ← 0x01 and 0x00 ← 0x01, then read frame 0x04AA → `pwm_duty_cycle` = 0x80, `en_reg_pwm_7_0` = 0x01; the read changes nothing.
- Out-of-range 0x8555 (addr 0x05); 15-bit frame toward addr 0x01; 17-bit frame toward addr 0x01 → all registers unchanged.
- Assert `rst_n` after bit 8 of frame 0x83FF while nCS stays low, release reset, then raise nCS → `en_reg_pwm_15_8` stays 0x00. The next full frame 0x83FF sets it to 0xFF.
- Back-to-back frames 0x8011 then 0x8022 with minimum nCS high time → final `en_reg_out_7_0` = 0x22, and 0x11 is visible in between.
